mem_req_arbiter: RTL and testbench

Front-end scheduler that shares the single byte-serial memory controller between three requesters: the Fetcher (instruction fetch), the LSB (loads) and the ROB (committed stores). Each requester gets a one-entry holding slot. A fixed-priority policy with fetch aging selects one request at a time, issues it to the memory controller and tracks it until the controller reports completion. Flush drops speculative (fetch/load) work and preserves stores.

---
 rtl/mem_req_arbiter_pkg.sv | 28 ++
 rtl/mem_req_arbiter_if.sv | 45 ++++
 rtl/mem_req_arbiter_req_slot.sv | 35 +++
 rtl/mem_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared widths, opcode encodings, requester kinds and FSM state encoding
// for the memory request arbiter.
package mem_req_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int INST_OP_WIDTH  = 6;
  localparam int DEF_AGE_LIMIT  = 3;

  localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd1;
  localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd2;
  localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd3;
  localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd4;
  localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd5;
  localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd6;
  localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd7;
  localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd8;

  localparam logic [1:0] ARB_KIND_FETCH = 2'd0;
  localparam logic [1:0] ARB_KIND_LOAD  = 2'd1;
  localparam logic [1:0] ARB_KIND_STORE = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester, controller and issue signals of the memory request arbiter.
// slave = arbiter side, master = requesters plus memory controller.
interface mem_req_arbiter_if;
  import mem_req_arbiter_pkg::*;

  logic                      fet_req;
  logic [XLEN-1:0]           fet_pc;
  logic                      fet_ready;
  logic                      lsb_req;
  logic [INST_OP_WIDTH-1:0]  lsb_op;
  logic [XLEN-1:0]           lsb_addr;
  logic [ROB_SIZE_WIDTH-1:0] lsb_id;
  logic                      lsb_ready;
  logic                      rob_req;
  logic [INST_OP_WIDTH-1:0]  rob_op;
  logic [XLEN-1:0]           rob_addr;
  logic [XLEN-1:0]           rob_val;
  logic                      rob_ready;
  logic                      mc_busy;
  logic                      mc_done;
  logic                      arb_valid;
  logic [1:0]                arb_kind;
  logic [INST_OP_WIDTH-1:0]  arb_op;
  logic [XLEN-1:0]           arb_addr;
  logic [XLEN-1:0]           arb_val;
  logic [ROB_SIZE_WIDTH-1:0] arb_id;
  logic                      arb_fet_done;
  logic                      arb_lsb_done;
  logic                      arb_rob_done;

  modport slave (
    input  fet_req, fet_pc, lsb_req, lsb_op, lsb_addr, lsb_id,
           rob_req, rob_op, rob_addr, rob_val, mc_busy, mc_done,
    output fet_ready, lsb_ready, rob_ready, arb_valid, arb_kind, arb_op,
           arb_addr, arb_val, arb_id, arb_fet_done, arb_lsb_done, arb_rob_done
  );

  modport master (
    output fet_req, fet_pc, lsb_req, lsb_op, lsb_addr, lsb_id,
           rob_req, rob_op, rob_addr, rob_val, mc_busy, mc_done,
    input  fet_ready, lsb_ready, rob_ready, arb_valid, arb_kind, arb_op,
           arb_addr, arb_val, arb_id, arb_fet_done, arb_lsb_done, arb_rob_done
  );

endinterface

// File: rtl/mem_req_arbiter_req_slot.sv
// One-entry valid+payload holding register: captures on req while empty,
// empties on completion, or on flush when the slot is speculative.
module mem_req_arbiter_req_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         req,
  input  logic [W-1:0] din,
  input  logic         clr,
  input  logic         flush,
  input  logic         flush_en,
  output logic         full,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (en) begin
      // Flush beats a same-cycle request so nothing speculative survives it.
      if (flush && flush_en) begin
        full <= 1'b0;
      end else if (clr) begin
        full <= 1'b0;
      end else if (req && !full) begin
        full <= 1'b1;
        q    <= din;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the byte-serial memory controller between fetch, load and store
// requesters: store > load > fetch, with fetch forced after AGE_LIMIT bypasses.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               flush,
  mem_req_arbiter_if.slave   bus
);

  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam int LSB_W = INST_OP_WIDTH + XLEN + ROB_SIZE_WIDTH;
  localparam int ROB_W = INST_OP_WIDTH + 2 * XLEN;

  arb_state_t                state, state_nxt;
  logic [AGE_W-1:0]          age, age_nxt;
  logic [1:0]                kind_q, win;
  logic                      grant;
  logic [INST_OP_WIDTH-1:0]  sel_op, op_q;
  logic [XLEN-1:0]           sel_addr, addr_q, sel_val, val_q;
  logic [ROB_SIZE_WIDTH-1:0] sel_id, id_q;
  logic                      valid_q;
  logic                      fet_done_nxt, lsb_done_nxt, rob_done_nxt;
  logic                      fet_done_q, lsb_done_q, rob_done_q;
  logic                      fet_full, lsb_full, rob_full;
  logic                      fet_pend, lsb_pend, rob_pend;
  logic [XLEN-1:0]           fet_q;
  logic [LSB_W-1:0]          lsb_q;
  logic [ROB_W-1:0]          rob_q;

  mem_req_arbiter_req_slot #(.W(XLEN)) u_fet_slot (
    .clk(clk), .rst_n(rst_n), .en(rdy), .req(bus.fet_req), .din(bus.fet_pc),
    .clr(fet_done_nxt), .flush(flush), .flush_en(1'b1), .full(fet_full), .q(fet_q)
  );

  mem_req_arbiter_req_slot #(.W(LSB_W)) u_lsb_slot (
    .clk(clk), .rst_n(rst_n), .en(rdy), .req(bus.lsb_req),
    .din({bus.lsb_op, bus.lsb_addr, bus.lsb_id}),
    .clr(lsb_done_nxt), .flush(flush), .flush_en(1'b1), .full(lsb_full), .q(lsb_q)
  );

  mem_req_arbiter_req_slot #(.W(ROB_W)) u_rob_slot (
    .clk(clk), .rst_n(rst_n), .en(rdy), .req(bus.rob_req),
    .din({bus.rob_op, bus.rob_addr, bus.rob_val}),
    .clr(rob_done_nxt), .flush(flush), .flush_en(1'b0), .full(rob_full), .q(rob_q)
  );

  // A flushing cycle sees the speculative slots as already empty.
  assign fet_pend = fet_full && !flush;
  assign lsb_pend = lsb_full && !flush;
  assign rob_pend = rob_full;

  always_comb begin
    state_nxt    = state;
    age_nxt      = age;
    grant        = 1'b0;
    win          = ARB_KIND_FETCH;
    sel_op       = '0;
    sel_addr     = '0;
    sel_val      = '0;
    sel_id       = '0;
    fet_done_nxt = 1'b0;
    lsb_done_nxt = 1'b0;
    rob_done_nxt = 1'b0;

    if (fet_pend && age == AGE_W'(AGE_LIMIT)) win = ARB_KIND_FETCH;
    else if (rob_pend)                        win = ARB_KIND_STORE;
    else if (lsb_pend)                        win = ARB_KIND_LOAD;

    case (win)
      ARB_KIND_STORE: {sel_op, sel_addr, sel_val} = rob_q;
      ARB_KIND_LOAD:  {sel_op, sel_addr, sel_id}  = lsb_q;
      default:        sel_addr = fet_q;
    endcase

    case (state)
      ST_IDLE: begin
        if (!bus.mc_busy && (fet_pend || lsb_pend || rob_pend)) begin
          grant     = 1'b1;
          state_nxt = ST_WAIT;
          if (win == ARB_KIND_FETCH)                   age_nxt = '0;
          else if (fet_pend && age != AGE_W'(AGE_LIMIT)) age_nxt = age + AGE_W'(1);
        end
      end
      ST_WAIT: begin
        // Speculative work is abandoned on flush; its late completion is dropped.
        if (flush && kind_q != ARB_KIND_STORE) begin
          state_nxt = ST_IDLE;
        end else if (bus.mc_done) begin
          state_nxt    = ST_IDLE;
          fet_done_nxt = (kind_q == ARB_KIND_FETCH);
          lsb_done_nxt = (kind_q == ARB_KIND_LOAD);
          rob_done_nxt = (kind_q == ARB_KIND_STORE);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (flush) age_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      age        <= '0;
      kind_q     <= ARB_KIND_FETCH;
      valid_q    <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      val_q      <= '0;
      id_q       <= '0;
      fet_done_q <= 1'b0;
      lsb_done_q <= 1'b0;
      rob_done_q <= 1'b0;
    end else if (rdy) begin
      state      <= state_nxt;
      age        <= age_nxt;
      valid_q    <= grant;
      fet_done_q <= fet_done_nxt;
      lsb_done_q <= lsb_done_nxt;
      rob_done_q <= rob_done_nxt;
      if (grant) begin
        kind_q <= win;
        op_q   <= sel_op;
        addr_q <= sel_addr;
        val_q  <= sel_val;
        id_q   <= sel_id;
      end
    end
  end

  assign bus.fet_ready    = !fet_full;
  assign bus.lsb_ready    = !lsb_full;
  assign bus.rob_ready    = !rob_full;
  assign bus.arb_valid    = valid_q;
  assign bus.arb_kind     = kind_q;
  assign bus.arb_op       = op_q;
  assign bus.arb_addr     = addr_q;
  assign bus.arb_val      = val_q;
  assign bus.arb_id       = id_q;
  assign bus.arb_fet_done = fet_done_q && rdy;
  assign bus.arb_lsb_done = lsb_done_q && rdy;
  assign bus.arb_rob_done = rob_done_q && rdy;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: single-request vector table, then ordering,
// aging, flush, stall and reset sequences against an issue scoreboard.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic flush = 1'b0;

  mem_req_arbiter_if bus();

  mem_req_arbiter #(.AGE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] val;
    logic [3:0]  id;
  } iss_t;

  typedef struct {
    int          who;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] val;
    logic [3:0]  id;
    iss_t        exp;
    logic [2:0]  exp_done;
  } vec_t;

  iss_t sb[$];
  vec_t vecs[6];
  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_vld = 1'b0;

  function automatic iss_t mk(logic [1:0] k, logic [5:0] op, logic [31:0] a,
                              logic [31:0] v, logic [3:0] id);
    iss_t r;
    r.kind = k; r.op = op; r.addr = a; r.val = v; r.id = id;
    return r;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] dones();
    return {bus.arb_fet_done, bus.arb_lsb_done, bus.arb_rob_done};
  endfunction

  function automatic logic [2:0] readies();
    return {bus.fet_ready, bus.lsb_ready, bus.rob_ready};
  endfunction

  task automatic drive(int who, logic [5:0] op, logic [31:0] a, logic [31:0] v, logic [3:0] id);
    case (who)
      0: begin bus.fet_req = 1'b1; bus.fet_pc = a; end
      1: begin bus.lsb_req = 1'b1; bus.lsb_op = op; bus.lsb_addr = a; bus.lsb_id = id; end
      default: begin bus.rob_req = 1'b1; bus.rob_op = op; bus.rob_addr = a; bus.rob_val = v; end
    endcase
  endtask

  task automatic drop_all();
    bus.fet_req = 1'b0;
    bus.lsb_req = 1'b0;
    bus.rob_req = 1'b0;
  endtask

  task automatic wait_valid(string nm);
    int k = 0;
    while (!bus.arb_valid && k < 40) begin
      tick();
      k++;
    end
    if (!bus.arb_valid) begin
      n_chk++;
      $display("FAIL %s_issue_timeout: arb_valid never rose within 40 cycles", nm);
    end
  endtask

  // Completes the in-flight request three cycles after issue and checks routing.
  task automatic complete(string nm, logic [2:0] exp_done);
    tick();
    tick();
    bus.mc_done = 1'b1;
    tick();
    bus.mc_done = 1'b0;
    check({nm, "_done"}, dones(), exp_done);
    check({nm, "_ready"}, readies() & exp_done, exp_done);
    bus.mc_busy = 1'b1;
    tick();
    check({nm, "_done_one_cycle"}, dones(), 3'b000);
    bus.mc_busy = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    iss_t got;
    if (rst_n && bus.arb_valid) begin
      got = mk(bus.arb_kind, bus.arb_op, bus.arb_addr, bus.arb_val, bus.arb_id);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_issue: got %0h expected no issue", got);
      end else begin
        check("issue", got, sb.pop_front());
      end
      check("valid_single_cycle", prev_vld, 1'b0);
    end
    prev_vld = bus.arb_valid;
  end

  initial begin
    vecs[0] = '{0, 6'd0,   32'h0000_0100, 32'h0,         4'd0,  mk(ARB_KIND_FETCH, 6'd0, 32'h100, 32'h0, 4'd0), 3'b100};
    vecs[1] = '{1, OP_LW,  32'h0000_2000, 32'h0,         4'd5,  mk(ARB_KIND_LOAD, OP_LW, 32'h2000, 32'h0, 4'd5), 3'b010};
    vecs[2] = '{1, OP_LBU, 32'hFFFF_FFFF, 32'h0,         4'd15, mk(ARB_KIND_LOAD, OP_LBU, 32'hFFFF_FFFF, 32'h0, 4'd15), 3'b010};
    vecs[3] = '{2, OP_SB,  32'h0000_0044, 32'h1234_5678, 4'd0,  mk(ARB_KIND_STORE, OP_SB, 32'h44, 32'h1234_5678, 4'd0), 3'b001};
    vecs[4] = '{2, OP_SH,  32'h8000_0002, 32'hFFFF_FFFF, 4'd0,  mk(ARB_KIND_STORE, OP_SH, 32'h8000_0002, 32'hFFFF_FFFF, 4'd0), 3'b001};
    vecs[5] = '{0, 6'd0,   32'hFFFF_FFFC, 32'h0,         4'd0,  mk(ARB_KIND_FETCH, 6'd0, 32'hFFFF_FFFC, 32'h0, 4'd0), 3'b100};

    bus.fet_req = 0; bus.fet_pc = 0;
    bus.lsb_req = 0; bus.lsb_op = 0; bus.lsb_addr = 0; bus.lsb_id = 0;
    bus.rob_req = 0; bus.rob_op = 0; bus.rob_addr = 0; bus.rob_val = 0;
    bus.mc_busy = 0; bus.mc_done = 0;
    rdy = 1'b1;
    #3;
    check("reset_outputs", {bus.arb_valid, bus.arb_kind, bus.arb_op, bus.arb_addr, bus.arb_val, bus.arb_id}, '0);
    check("reset_dones", dones(), 3'b000);
    check("reset_readies", readies(), 3'b111);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].who, vecs[i].op, vecs[i].addr, vecs[i].val, vecs[i].id);
      tick();
      drop_all();
      check($sformatf("vec%0d_accept", i), readies() & vecs[i].exp_done, 3'b000);
      check($sformatf("vec%0d_latency", i), bus.arb_valid, 1'b0);
      sb.push_back(vecs[i].exp);
      tick();
      wait_valid($sformatf("vec%0d", i));
      complete($sformatf("vec%0d", i), vecs[i].exp_done);
    end

    // Simultaneous requests issue store, load, fetch.
    drive(0, 6'd0, 32'h1000, 32'h0, 4'd0);
    drive(1, OP_LW, 32'h2000, 32'h0, 4'd5);
    drive(2, OP_SW, 32'h3000, 32'hDEAD_BEEF, 4'd0);
    tick();
    drop_all();
    sb.push_back(mk(ARB_KIND_STORE, OP_SW, 32'h3000, 32'hDEAD_BEEF, 4'd0));
    sb.push_back(mk(ARB_KIND_LOAD, OP_LW, 32'h2000, 32'h0, 4'd5));
    sb.push_back(mk(ARB_KIND_FETCH, 6'd0, 32'h1000, 32'h0, 4'd0));
    wait_valid("simul_s"); complete("simul_s", 3'b001);
    wait_valid("simul_l"); complete("simul_l", 3'b010);
    wait_valid("simul_f"); complete("simul_f", 3'b100);

    // Aging: stores and loads keep re-requesting; fetch forced on the 4th grant.
    bus.mc_busy = 1'b1;
    drive(0, 6'd0, 32'h400, 32'h0, 4'd0);
    drive(1, OP_LH, 32'h500, 32'h0, 4'd3);
    drive(2, OP_SW, 32'h600, 32'hA5A5_A5A5, 4'd0);
    tick();
    bus.fet_req = 1'b0;
    for (int g = 0; g < 3; g++) sb.push_back(mk(ARB_KIND_STORE, OP_SW, 32'h600, 32'hA5A5_A5A5, 4'd0));
    sb.push_back(mk(ARB_KIND_FETCH, 6'd0, 32'h400, 32'h0, 4'd0));
    sb.push_back(mk(ARB_KIND_STORE, OP_SW, 32'h600, 32'hA5A5_A5A5, 4'd0));
    sb.push_back(mk(ARB_KIND_LOAD, OP_LH, 32'h500, 32'h0, 4'd3));
    bus.mc_busy = 1'b0;
    for (int g = 0; g < 3; g++) begin
      wait_valid("age_store");
      if (g == 2) check("age_saturated", dut.age, 2'd3);
      complete("age_store", 3'b001);
    end
    wait_valid("age_fetch");
    drop_all();
    check("age_cleared", dut.age, 2'd0);
    complete("age_fetch", 3'b100);
    wait_valid("age_drain_s"); complete("age_drain_s", 3'b001);
    wait_valid("age_drain_l"); complete("age_drain_l", 3'b010);

    // Flush during in-flight LW with pending fetch and SB.
    drive(1, OP_LW, 32'h7000, 32'h0, 4'd2);
    tick();
    drop_all();
    sb.push_back(mk(ARB_KIND_LOAD, OP_LW, 32'h7000, 32'h0, 4'd2));
    wait_valid("flush_lw");
    drive(0, 6'd0, 32'h800, 32'h0, 4'd0);
    drive(2, OP_SB, 32'h900, 32'h77, 4'd0);
    tick();
    drop_all();
    sb.push_back(mk(ARB_KIND_STORE, OP_SB, 32'h900, 32'h77, 4'd0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_lw_readies", readies(), 3'b110);
    check("flush_lw_no_done", dones(), 3'b000);
    bus.mc_done = 1'b1;
    tick();
    bus.mc_done = 1'b0;
    check("flush_stray_done", dones(), 3'b000);
    check("flush_next_is_sb", bus.arb_valid, 1'b1);
    complete("flush_sb", 3'b001);

    // Flush and mc_done in the same cycle for a load: no done pulse.
    drive(1, OP_LB, 32'hA00, 32'h0, 4'd1);
    tick();
    drop_all();
    sb.push_back(mk(ARB_KIND_LOAD, OP_LB, 32'hA00, 32'h0, 4'd1));
    wait_valid("flush_done_lb");
    tick();
    flush = 1'b1;
    bus.mc_done = 1'b1;
    tick();
    flush = 1'b0;
    bus.mc_done = 1'b0;
    check("flush_beats_done", dones(), 3'b000);
    check("flush_beats_done_ready", bus.lsb_ready, 1'b1);

    // Flush during in-flight SW, with a same-cycle fetch request.
    drive(2, OP_SW, 32'hB00, 32'hCAFE_F00D, 4'd0);
    tick();
    drop_all();
    sb.push_back(mk(ARB_KIND_STORE, OP_SW, 32'hB00, 32'hCAFE_F00D, 4'd0));
    wait_valid("flush_sw");
    tick();
    flush = 1'b1;
    drive(0, 6'd0, 32'hC00, 32'h0, 4'd0);
    tick();
    flush = 1'b0;
    drop_all();
    check("flush_sw_fet_ready", bus.fet_ready, 1'b1);
    check("flush_sw_kept", bus.rob_ready, 1'b0);
    complete("flush_sw", 3'b001);

    // rdy low freezes everything, even with mc_done and a fetch request present.
    drive(2, OP_SH, 32'hD00, 32'h1234, 4'd0);
    tick();
    drop_all();
    sb.push_back(mk(ARB_KIND_STORE, OP_SH, 32'hD00, 32'h1234, 4'd0));
    wait_valid("stall");
    tick();
    rdy = 1'b0;
    bus.mc_done = 1'b1;
    drive(0, 6'd0, 32'hE00, 32'h0, 4'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall_c%0d", c),
            {readies(), dones(), bus.arb_valid, 1'(dut.state)}, {3'b110, 3'b000, 1'b0, 1'b1});
    end
    bus.mc_done = 1'b0;
    drop_all();
    rdy = 1'b1;
    complete("stall_resume", 3'b001);

    // Asynchronous reset while a load is being issued with a fetch pending.
    drive(0, 6'd0, 32'hF00, 32'h0, 4'd0);
    drive(1, OP_LHU, 32'h1100, 32'h0, 4'd7);
    tick();
    drop_all();
    tick();
    check("pre_reset_issue", {bus.arb_valid, bus.arb_kind}, {1'b1, ARB_KIND_LOAD});
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {bus.arb_valid, bus.arb_kind, bus.arb_op, bus.arb_addr, bus.arb_id}, '0);
    check("reset_mid_readies", readies(), 3'b111);
    tick();
    rst_n = 1'b1;
    bus.mc_done = 1'b1;
    tick();
    bus.mc_done = 1'b0;
    check("reset_stray_done", {dones(), bus.arb_valid}, 4'b0000);
    drive(0, 6'd0, 32'h1200, 32'h0, 4'd0);
    tick();
    drop_all();
    sb.push_back(mk(ARB_KIND_FETCH, 6'd0, 32'h1200, 32'h0, 4'd0));
    wait_valid("post_reset");
    complete("post_reset", 3'b100);

    tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
